// File: rtl/ee354_gcd_sequencer.sv
// Drives the ee354 GCD core through its Start/Ack handshake for each entry of a
// small operand table, keeping per-entry results and timeout flags for readback.
module ee354_gcd_sequencer #(
  parameter int W       = 8,
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Ld_en,
  input  logic [AW-1:0] Ld_addr,
  input  logic [W-1:0]  Ld_A,
  input  logic [W-1:0]  Ld_B,
  input  logic [AW:0]   Num_pairs,
  input  logic          Go,
  input  logic [AW-1:0] Rd_addr,
  output logic [W-1:0]  Rd_gcd,
  output logic          Rd_err,
  output logic          Busy,
  output logic          Done,
  output logic          Timeout,
  output logic          Core_Start,
  output logic          Core_Ack,
  output logic [W-1:0]  Core_Ain,
  output logic [W-1:0]  Core_Bin,
  input  logic [W-1:0]  Core_AB_GCD,
  input  logic          Core_q_I,
  input  logic          Core_q_Done
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [AW:0]   DEPTH_N  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

  typedef enum logic [6:0] {
    S_IDLE  = 7'b0000001,
    S_CHECK = 7'b0000010,
    S_ISSUE = 7'b0000100,
    S_WAIT  = 7'b0001000,
    S_ACK   = 7'b0010000,
    S_NEXT  = 7'b0100000,
    S_FIN   = 7'b1000000
  } state_t;

  state_t        state_q;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] idx_d;
  logic [AW:0]   n_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          busy_q;
  logic          done_q;
  logic          timeout_q;
  logic          start_q;
  logic          ack_q;
  logic [W-1:0]  ain_q;
  logic [W-1:0]  bin_q;
  logic [W-1:0]  res_q [DEPTH];
  logic [DEPTH-1:0] err_q;
  logic [W-1:0]  tbl_a_q [DEPTH];
  logic [W-1:0]  tbl_b_q [DEPTH];

  logic [W-1:0]  cur_a_s;
  logic [W-1:0]  cur_b_s;
  logic [AW:0]   n_clamp_s;
  logic          last_s;

  assign idx_d     = idx_q + AW'(1);
  assign cnt_d     = cnt_q + CW'(1);
  assign cur_a_s   = tbl_a_q[idx_q];
  assign cur_b_s   = tbl_b_q[idx_q];
  assign n_clamp_s = (Num_pairs > DEPTH_N) ? DEPTH_N : Num_pairs;
  // idx is also capped at the last table slot so it can never wrap
  assign last_s    = ((AW+1)'(idx_q) == (n_q - (AW+1)'(1))) || (idx_q == IDX_LAST);

  // Operand table: writable only while idle, deliberately not cleared by reset
  always_ff @(posedge Clk) begin
    if (state_q == S_IDLE && Ld_en) begin
      tbl_a_q[Ld_addr] <= Ld_A;
      tbl_b_q[Ld_addr] <= Ld_B;
    end
  end

  // Batch sequencer, core handshake and result capture
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      n_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      start_q   <= 1'b0;
      ack_q     <= 1'b0;
      ain_q     <= '0;
      bin_q     <= '0;
      err_q     <= '0;
      for (int i = 0; i < DEPTH; i++) res_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Go) begin
            timeout_q <= 1'b0;
            idx_q     <= '0;
            n_q       <= n_clamp_s;
            err_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= (Num_pairs == '0) ? S_FIN : S_CHECK;
          end
        end
        S_CHECK: begin
          // The core never terminates on a zero operand, so resolve it here
          if (cur_a_s == '0 || cur_b_s == '0) begin
            res_q[idx_q] <= cur_a_s | cur_b_s;
            state_q      <= S_NEXT;
          end else begin
            ain_q   <= cur_a_s;
            bin_q   <= cur_b_s;
            start_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!Core_q_I) begin
            start_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          if (Core_q_Done) begin
            res_q[idx_q] <= Core_AB_GCD;
            ack_q        <= 1'b1;
            state_q      <= S_ACK;
          end else if (cnt_q == CNT_LAST) begin
            err_q[idx_q] <= 1'b1;
            res_q[idx_q] <= '0;
            timeout_q    <= 1'b1;
            state_q      <= S_FIN;
          end
        end
        S_ACK: begin
          if (Core_q_I) begin
            ack_q   <= 1'b0;
            state_q <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (last_s) begin
            state_q <= S_FIN;
          end else begin
            idx_q   <= idx_d;
            state_q <= S_CHECK;
          end
        end
        S_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          start_q <= 1'b0;
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Rd_gcd     = res_q[Rd_addr];
  assign Rd_err     = err_q[Rd_addr];
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Timeout    = timeout_q;
  assign Core_Start = start_q;
  assign Core_Ack   = ack_q;
  assign Core_Ain   = ain_q;
  assign Core_Bin   = bin_q;

endmodule
